// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add/subtract time-multiplexed over one 4-bit ripple-carry slice
//
// Purpose:
//   Accepts an operand pair over a valid/ready handshake and computes A+B+cin
//   or A-B (as A+~B+1). It runs the single 4-bit slice once per nibble,
//   least-significant nibble first. The result is then presented over a
//   second valid/ready handshake until the consumer takes it.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  operand request valid
//   start_ready  request can be accepted (IDLE decode)
//   a, b         operands, sampled on the accept edge only
//   cin          carry-in for add; ignored for subtract
//   sub          0: A+B+cin, 1: A-B
//   result       registered sum/difference, meaningful while done_valid=1
//   cout         carry out of the MSB nibble (1 = no borrow when sub=1)
//   done_valid   result/cout valid
//   done_ready   consumer accepts the result
//   busy         operation in progress or awaiting hand-off

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    // Keep the counter at least one bit wide so a single-nibble instance still elaborates.
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             done_valid_q;

    // Nibble views of the captured operands, selected by the counter.
    logic [3:0] opa_nib [NIB];
    logic [3:0] opb_nib [NIB];

    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign opa_nib[gi] = opa_q[4*gi +: 4];
        assign opb_nib[gi] = opb_q[4*gi +: 4];
    end

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_sum;
    logic [4:0] slice_c;
    logic       slice_cout;
    logic       last_nib;

    // The shared 4-bit ripple-carry slice: a plain full-adder chain.
    always_comb begin
        slice_a    = opa_nib[k_q];
        slice_b    = opb_nib[k_q];
        slice_sum  = '0;
        slice_c    = '0;
        slice_c[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i]  = slice_a[i] ^ slice_b[i] ^ slice_c[i];
            slice_c[i+1]  = (slice_a[i] & slice_b[i]) | (slice_c[i] & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = slice_c[4];
    end

    assign last_nib = (k_q == KW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            carry_q      <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            result_q     <= '0;
            cout_q       <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        opa_q    <= a;
                        // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
                        opb_q    <= sub ? ~b : b;
                        carry_q  <= sub ? 1'b1 : cin;
                        k_q      <= '0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (k_q == KW'(i)) begin
                            result_q[4*i +: 4] <= slice_sum;
                        end
                    end
                    carry_q <= slice_cout;
                    if (last_nib) begin
                        k_q          <= '0;
                        cout_q       <= slice_cout;
                        done_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_DONE: begin
                    if (done_ready) begin
                        done_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign result      = result_q;
    assign cout        = cout_q;
    assign done_valid  = done_valid_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed-vector bench for nibble_serial_adder_ctrl (WIDTH=16 and WIDTH=4)

module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;

    logic        start_valid;
    logic        start_ready;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin;
    logic        sub;
    logic [15:0] result;
    logic        cout;
    logic        done_valid;
    logic        done_ready;
    logic        busy;

    logic        w4_start_valid;
    logic        w4_start_ready;
    logic [3:0]  w4_a;
    logic [3:0]  w4_b;
    logic        w4_cin;
    logic        w4_sub;
    logic [3:0]  w4_result;
    logic        w4_cout;
    logic        w4_done_valid;
    logic        w4_done_ready;
    logic        w4_busy;

    int total;
    int bad;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a16),
        .b           (b16),
        .cin         (cin),
        .sub         (sub),
        .result      (result),
        .cout        (cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut_w4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (w4_start_valid),
        .start_ready (w4_start_ready),
        .a           (w4_a),
        .b           (w4_b),
        .cin         (w4_cin),
        .sub         (w4_sub),
        .result      (w4_result),
        .cout        (w4_cout),
        .done_valid  (w4_done_valid),
        .done_ready  (w4_done_ready),
        .busy        (w4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!start_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!start_ready) chk({tag, "_ready_timeout"}, 32'(start_ready), 32'd1);
    endtask

    // One full operation on the 16-bit instance. hold>0 adds a start_valid
    // pulse during RUN and holds done_ready low for 'hold' cycles in DONE.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub,
                         input logic [15:0] eres, input logic ecout, input int hold);
        int  n;
        bit  seen;
        wait_ready(tag);
        a16 = ta; b16 = tb_v; cin = tcin; sub = tsub;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        // Operands may change freely after the accept edge.
        a16 = 16'hDEAD; b16 = 16'hBEEF; cin = ~tcin; sub = ~tsub;
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        chk({tag, "_sready_run"}, 32'(start_ready), 32'd0);
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            start_valid = (hold > 0 && n == 1);
            @(posedge clk); #1;
            n++;
            if (done_valid) seen = 1;
        end
        start_valid = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_result"}, 32'(result), 32'(eres));
        chk({tag, "_cout"}, 32'(cout), 32'(ecout));
        for (int h = 0; h < hold; h++) begin
            start_valid = 1'b1;
            a16 = 16'h0F0F; b16 = 16'h0101;
            @(posedge clk); #1;
            chk({tag, "_hold_result"}, 32'(result), 32'(eres));
            chk({tag, "_hold_cout"}, 32'(cout), 32'(ecout));
            chk({tag, "_hold_dvalid"}, 32'(done_valid), 32'd1);
            chk({tag, "_hold_sready"}, 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        chk({tag, "_dvalid_drop"}, 32'(done_valid), 32'd0);
        chk({tag, "_sready_idle"}, 32'(start_ready), 32'd1);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        start_valid = 1'b0; a16 = '0; b16 = '0; cin = 1'b0; sub = 1'b0; done_ready = 1'b0;
        w4_start_valid = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0; w4_sub = 1'b0; w4_done_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_dvalid", 32'(done_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sready", 32'(start_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 0);
        do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
        do_op("add_cin",    16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 0);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 0);
        do_op("sub_msb",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 0);
        do_op("sub_equal",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 0);
        do_op("backpress",  16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 3);
        // The pulses during RUN/DONE must not have started another operation.
        @(posedge clk); #1;
        chk("after_bp_busy", 32'(busy), 32'd0);
        chk("after_bp_dvalid", 32'(done_valid), 32'd0);

        // Reset during the 2nd RUN cycle.
        wait_ready("rst_mid");
        a16 = 16'h1111; b16 = 16'h2222; cin = 1'b0; sub = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        chk("partial_low_nib", 32'(result), 32'h0003);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_dvalid", 32'(done_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sready", 32'(start_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 0);

        // Single-nibble instance.
        w4_a = 4'hF; w4_b = 4'hF; w4_cin = 1'b1; w4_sub = 1'b0;
        w4_start_valid = 1'b1;
        @(posedge clk); #1;
        w4_start_valid = 1'b0;
        chk("w4_busy", 32'(w4_busy), 32'd1);
        @(posedge clk); #1;
        chk("w4_dvalid", 32'(w4_done_valid), 32'd1);
        chk("w4_result", 32'(w4_result), 32'hF);
        chk("w4_cout", 32'(w4_cout), 32'd1);
        w4_done_ready = 1'b1;
        @(posedge clk); #1;
        w4_done_ready = 1'b0;
        chk("w4_dvalid_drop", 32'(w4_done_valid), 32'd0);
        chk("w4_sready", 32'(w4_start_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
